// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory one word at a time and
// buffers a single fetched instruction for the decoder. A redirect flushes in-flight work.
module instr_fetch #(
  parameter int          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      // A request already on the bus must still be answered, so WAIT goes to DRAIN
      // unless the response arrives in this very cycle.
      pc          <= redirect_aligned;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      case (state)
        WAIT:    state <= imem_rvalid ? IDLE : DRAIN;
        DRAIN:   state <= imem_rvalid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(4);
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (en) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
